// File: rtl/ram_sp_arbiter.sv
// ram_sp_arbiter: shares one single-port synchronous RAM between the
// variable-node unit (requester 0) and the check-node unit (requester 1).
// Round-robin arbitration with an optional burst lock. The lock is bounded
// by a hold counter whenever the other requester is waiting. Read-valid
// strobes are aligned to the RAM's one-cycle registered read.
module ram_sp_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  // Counter must be able to hold the value MAX_HOLD itself.
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  owner_t          owner_reg;
  logic [HW-1:0]   hold_cnt_reg;
  logic            last_reg;
  logic            rvalid0_reg;
  logic            rvalid1_reg;

  logic            win0;
  logic            win1;
  logic            hold_ok;
  logic            win_lock;
  logic            win_same_owner;
  owner_t          owner_next;
  logic [HW-1:0]   hold_cnt_next;

  // Winner selection: an owner within its hold budget (or unopposed) keeps
  // the port, otherwise a tie goes to the requester that was not served last.
  always_comb begin
    win0    = 1'b0;
    win1    = 1'b0;
    hold_ok = (hold_cnt_reg < HOLD_MAX);
    if (owner_reg == OWN_P0 && req0 && (hold_ok || !req1)) begin
      win0 = 1'b1;
    end else if (owner_reg == OWN_P1 && req1 && (hold_ok || !req0)) begin
      win1 = 1'b1;
    end else if (req0 && req1) begin
      if (last_reg) win0 = 1'b1;
      else          win1 = 1'b1;
    end else if (req0) begin
      win0 = 1'b1;
    end else if (req1) begin
      win1 = 1'b1;
    end
  end

  assign gnt0 = win0;
  assign gnt1 = win1;

  // RAM pin mux: winner's request drives the port, everything is zero when idle.
  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (win0) begin
      ram_cs    = 1'b1;
      ram_we    = we0;
      ram_addr  = addr0;
      ram_wdata = wdata0;
    end else if (win1) begin
      ram_cs    = 1'b1;
      ram_we    = we1;
      ram_addr  = addr1;
      ram_wdata = wdata1;
    end
  end

  // Next ownership and hold count: a locking winner that already owned the
  // port extends its run (saturating), a fresh locking winner starts at one.
  always_comb begin
    win_lock       = win0 ? lock0 : (win1 ? lock1 : 1'b0);
    win_same_owner = (win0 && owner_reg == OWN_P0) || (win1 && owner_reg == OWN_P1);
    owner_next     = OWN_NONE;
    hold_cnt_next  = '0;
    if ((win0 || win1) && win_lock) begin
      owner_next = win0 ? OWN_P0 : OWN_P1;
      if (!win_same_owner)              hold_cnt_next = HOLD_ONE;
      else if (hold_cnt_reg >= HOLD_MAX) hold_cnt_next = HOLD_MAX;
      else                               hold_cnt_next = hold_cnt_reg + HOLD_ONE;
    end
  end

  // Arbiter state and read-valid strobes; reset discards any pending read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_reg    <= OWN_NONE;
      hold_cnt_reg <= '0;
      last_reg     <= 1'b1;
      rvalid0_reg  <= 1'b0;
      rvalid1_reg  <= 1'b0;
    end else begin
      owner_reg    <= owner_next;
      hold_cnt_reg <= hold_cnt_next;
      if (win0 || win1) last_reg <= win1;
      rvalid0_reg  <= win0 & ~we0;
      rvalid1_reg  <= win1 & ~we1;
    end
  end

  assign rvalid0 = rvalid0_reg;
  assign rvalid1 = rvalid1_reg;
  assign rdata0  = ram_rdata;
  assign rdata1  = ram_rdata;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Directed bench for ram_sp_arbiter with a behavioural single-port RAM and
// a read-return scoreboard.
module tb_ram_sp_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1, lock0, lock1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_cs, ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         port;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] shadow [256];
  logic [7:0] mem    [256];

  ram_sp_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int a);
    logic [7:0] v;
    v = 8'(a);
    return v ^ 8'h5A;
  endfunction

  // Behavioural single-port RAM with registered read.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pat(i);
    ram_rdata = 8'h00;
  end
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive requests, check read return of the previous cycle,
  // grant and RAM pins of this cycle, then advance past the clock edge.
  task automatic step(input logic r0, input logic l0, input logic w0,
                      input logic [7:0] a0, input logic [7:0] d0,
                      input logic r1, input logic l1, input logic w1,
                      input logic [7:0] a1, input logic [7:0] d1,
                      input logic eg0, input logic eg1, input string tag);
    exp_t        e;
    logic [17:0] pins;
    req0 = r0; lock0 = l0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; lock1 = l1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rvalid"}, {30'd0, rvalid1, rvalid0}, e.port ? 32'd2 : 32'd1);
      check({tag, "_rdata"}, {24'd0, e.port ? rdata1 : rdata0}, {24'd0, e.data});
    end else begin
      check({tag, "_rvalid"}, {30'd0, rvalid1, rvalid0}, 32'd0);
    end
    check({tag, "_gnt"}, {30'd0, gnt1, gnt0}, {30'd0, eg1, eg0});
    if (eg0)      pins = {1'b1, w0, a0, d0};
    else if (eg1) pins = {1'b1, w1, a1, d1};
    else          pins = 18'd0;
    check({tag, "_pins"}, {14'd0, ram_cs, ram_we, ram_addr, ram_wdata}, {14'd0, pins});
    if (eg0) begin
      if (w0) shadow[a0] = d0;
      else    sb.push_back('{port: 1'b0, data: shadow[a0]});
    end else if (eg1) begin
      if (w1) shadow[a1] = d1;
      else    sb.push_back('{port: 1'b1, data: shadow[a1]});
    end
    $display("step %-12s gnt=%b%b cs=%b we=%b addr=%h wdata=%h rvalid=%b%b", tag,
             gnt1, gnt0, ram_cs, ram_we, ram_addr, ram_wdata, rvalid1, rvalid0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 256; i++) shadow[i] = pat(i);
    rst = 1'b1;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    #1;
    check("reset_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    check("reset_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single read and idle
    step(1, 0, 0, 8'h12, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, "rd0_single");
    step(0, 0, 0, 8'h55, 8'h77, 0, 0, 0, 8'h66, 8'h88, 0, 0, "idle_a");

    // P1 write then read back
    step(0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h07, 8'hA5, 0, 1, "wr1");
    step(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h07, 8'h00, 0, 1, "rd1");

    // Round-robin with both requesting, P0 first
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 8'(8'h20 + i), 8'h00, 1, 0, 0, 8'(8'h30 + i), 8'h00,
           (i % 2) == 0, (i % 2) == 1, "rr");

    // Locked P0 burst; P1 waits from the third cycle and wins after four grants
    step(1, 1, 0, 8'h40, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, "hold0");
    step(1, 1, 0, 8'h41, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, "hold1");
    step(1, 1, 0, 8'h42, 8'h00, 1, 0, 0, 8'h50, 8'h00, 1, 0, "hold2");
    step(1, 1, 0, 8'h43, 8'h00, 1, 0, 0, 8'h50, 8'h00, 1, 0, "hold3");
    step(1, 1, 0, 8'h44, 8'h00, 1, 0, 0, 8'h50, 8'h00, 0, 1, "hold_expire");

    // Unopposed lock keeps the port indefinitely; count saturates
    for (int i = 0; i < 9; i++)
      step(1, 1, 0, 8'(8'h45 + i), 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, "hold_solo");
    step(1, 1, 0, 8'h4F, 8'h00, 1, 0, 0, 8'h51, 8'h00, 0, 1, "hold_sat");

    // Idle releases ownership: next tie goes to P1 since P0 was last
    step(1, 1, 0, 8'h60, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, "own0");
    step(0, 1, 1, 8'h61, 8'hC3, 0, 1, 1, 8'h62, 8'h3C, 0, 0, "idle_b");
    step(1, 0, 0, 8'h63, 8'h00, 1, 0, 0, 8'h64, 8'h00, 0, 1, "after_idle");

    // Write then read same address back-to-back
    step(1, 0, 1, 8'h80, 8'h3C, 0, 0, 0, 8'h00, 8'h00, 1, 0, "wr0");
    step(1, 0, 0, 8'h80, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, "rd0_new");

    // Reset in the cycle after a granted read
    step(1, 0, 0, 8'h12, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, "rd0_prerst");
    e = sb.pop_front();
    check("prerst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd1);
    check("prerst_rdata", {24'd0, rdata0}, {24'd0, e.data});
    req0 = 0; req1 = 0;
    rst = 1'b1;
    #1;
    check("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
    $display("step %-12s rvalid=%b%b", "rst_mid", rvalid1, rvalid0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 0, 0, 8'h70, 8'h00, 1, 0, 0, 8'h71, 8'h00, 1, 0, "tie_post_rst");
    step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, "idle_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
